// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM PIN-verification slice.
package atm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      CHECK,
      GRANTED,
      LOCKED,
      EJECT
   } pin_state_t;

   localparam int unsigned PIN_DIGITS      = 4;
   localparam int unsigned DEF_MAX_TRIES   = 3;
   localparam int unsigned DEF_TIMEOUT_CYC = 1000;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_verify_if.sv
// Card/keypad/status bundle between the card handler, keypad and the PIN verifier.
interface pin_verify_if #(
   parameter int unsigned PASS_WIDTH = 16
);
   logic                  pass_flag;
   logic [PASS_WIDTH-1:0] password;
   logic                  card_out;
   logic                  session_end;
   logic [3:0]            digit;
   logic                  digit_valid;
   logic                  pin_ok;
   logic                  pin_locked;
   logic                  eject_card;
   logic [1:0]            tries_left;
   logic [2:0]            digit_count;

   modport master (
      output pass_flag, password, card_out, session_end, digit, digit_valid,
      input  pin_ok, pin_locked, eject_card, tries_left, digit_count
   );

   modport slave (
      input  pass_flag, password, card_out, session_end, digit, digit_valid,
      output pin_ok, pin_locked, eject_card, tries_left, digit_count
   );
endinterface

// File: rtl/pin_timer.sv
// Saturating idle timer; expired holds once LIMIT-1 cycles have elapsed since clear.
module pin_timer #(
   parameter int unsigned LIMIT = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != LAST))
         count <= count + W'(1);
   end

   assign expired = (count == LAST);
endmodule

// File: rtl/pin_verify.sv
// ATM PIN entry/verification FSM: collects 4 BCD digits, compares, grants, locks or ejects.
module pin_verify
   import atm_pkg::*;
#(
   parameter int unsigned PASS_WIDTH  = 16,
   parameter int unsigned MAX_TRIES   = DEF_MAX_TRIES,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic         clk,
   input  logic         reset_n,
   pin_verify_if.slave  bus
);
   pin_state_t            state;
   logic [PASS_WIDTH-1:0] entry;
   logic [PASS_WIDTH-1:0] pin_ref;
   logic                  digit_acc;
   logic                  go_idle;
   logic                  timer_clr;
   logic                  timer_en;
   logic                  timer_exp;

   assign digit_acc = (state == ENTER) && bus.digit_valid && is_bcd(bus.digit) &&
                      (bus.digit_count < 3'(PIN_DIGITS)) && !bus.card_out;
   assign timer_clr = (state != ENTER) || digit_acc;
   assign timer_en  = (state == ENTER);

   pin_timer #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (timer_exp)
   );

   // Every exit to IDLE funnels through go_idle so the cleanup is written once.
   always_comb begin
      go_idle = 1'b0;
      unique case (state)
         ENTER, CHECK: go_idle = bus.card_out;
         GRANTED:      go_idle = bus.session_end || bus.card_out;
         LOCKED:       go_idle = bus.card_out;
         EJECT:        go_idle = 1'b1;
         default:      go_idle = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         entry           <= '0;
         pin_ref         <= '0;
         bus.pin_ok      <= 1'b0;
         bus.pin_locked  <= 1'b0;
         bus.eject_card  <= 1'b0;
         bus.tries_left  <= '0;
         bus.digit_count <= '0;
      end else begin
         bus.eject_card <= 1'b0;
         if (go_idle) begin
            state           <= IDLE;
            entry           <= '0;
            pin_ref         <= '0;
            bus.pin_ok      <= 1'b0;
            bus.pin_locked  <= 1'b0;
            bus.tries_left  <= '0;
            bus.digit_count <= '0;
         end else begin
            unique case (state)
               IDLE: if (bus.pass_flag) begin
                  pin_ref         <= bus.password;
                  entry           <= '0;
                  bus.tries_left  <= 2'(MAX_TRIES);
                  bus.digit_count <= '0;
                  state           <= ENTER;
               end
               ENTER: begin
                  if (bus.digit_count == 3'(PIN_DIGITS)) begin
                     state <= CHECK;
                  end else if (digit_acc) begin
                     entry           <= {entry[PASS_WIDTH-5:0], bus.digit};
                     bus.digit_count <= bus.digit_count + 3'd1;
                  end else if (timer_exp) begin
                     state          <= EJECT;
                     bus.eject_card <= 1'b1;
                  end
               end
               CHECK: begin
                  if (entry == pin_ref) begin
                     bus.pin_ok <= 1'b1;
                     state      <= GRANTED;
                  end else if (bus.tries_left <= 2'd1) begin
                     bus.tries_left <= '0;
                     bus.pin_locked <= 1'b1;
                     state          <= LOCKED;
                  end else begin
                     bus.tries_left  <= bus.tries_left - 2'd1;
                     entry           <= '0;
                     bus.digit_count <= '0;
                     state           <= ENTER;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pin_verify.sv
// Directed self-checking bench for pin_verify (timeout shortened to 8 cycles).
module tb_pin_verify;
   logic clk = 1'b0;
   logic reset_n;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   pin_verify_if #(.PASS_WIDTH(16)) bus_if ();

   pin_verify #(
      .PASS_WIDTH  (16),
      .MAX_TRIES   (3),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      bus_if.digit       = d;
      bus_if.digit_valid = 1'b1;
      tick();
      bus_if.digit_valid = 1'b0;
   endtask

   task automatic start(input logic [15:0] pw);
      bus_if.password  = pw;
      bus_if.pass_flag = 1'b1;
      tick();
      bus_if.pass_flag = 1'b0;
   endtask

   task automatic pulse_card_out();
      bus_if.card_out = 1'b1;
      tick();
      bus_if.card_out = 1'b0;
   endtask

   initial begin
      logic [3:0] seq39 [5];
      logic [2:0] dc39  [5];
      logic       early_eject;

      reset_n            = 1'b0;
      bus_if.pass_flag   = 1'b0;
      bus_if.password    = '0;
      bus_if.card_out    = 1'b0;
      bus_if.session_end = 1'b0;
      bus_if.digit       = '0;
      bus_if.digit_valid = 1'b0;
      #1;
      check("rst_pin_ok", bus_if.pin_ok, 0);
      check("rst_locked", bus_if.pin_locked, 0);
      check("rst_tries", bus_if.tries_left, 0);
      check("rst_count", bus_if.digit_count, 0);
      #11 reset_n = 1'b1;
      tick();
      check("idle_no_pass", bus_if.tries_left, 0);

      // Correct PIN, grant latency, ignored digit and session_end in GRANTED
      start(16'h3370);
      check("start_tries", bus_if.tries_left, 3);
      press(4'd3); press(4'd3); press(4'd7); press(4'd0);
      check("ok_count4", bus_if.digit_count, 4);
      check("ok_n", bus_if.pin_ok, 0);
      tick();
      check("ok_n1", bus_if.pin_ok, 0);
      tick();
      check("ok_n2", bus_if.pin_ok, 1);
      check("ok_tries", bus_if.tries_left, 3);
      press(4'd5);
      check("granted_digit_ok", bus_if.pin_ok, 1);
      check("granted_digit_cnt", bus_if.digit_count, 4);
      bus_if.session_end = 1'b1;
      tick();
      bus_if.session_end = 1'b0;
      check("sess_end_ok", bus_if.pin_ok, 0);
      check("sess_end_tries", bus_if.tries_left, 0);

      // Three wrong attempts lock the card
      start(16'h3506);
      for (int a = 0; a < 3; a++) begin
         for (int k = 0; k < 4; k++) press(4'd1);
         tick();
         tick();
         check("wrong_tries", bus_if.tries_left, 32'(2 - a));
         check("wrong_locked", bus_if.pin_locked, (a == 2) ? 1 : 0);
         check("wrong_ok", bus_if.pin_ok, 0);
         if (a < 2) check("wrong_count_clr", bus_if.digit_count, 0);
      end
      pulse_card_out();
      check("unlock_locked", bus_if.pin_locked, 0);
      check("unlock_tries", bus_if.tries_left, 0);
      check("unlock_count", bus_if.digit_count, 0);
      check("unlock_eject", bus_if.eject_card, 0);

      // Non-BCD digit is ignored
      seq39 = '{4'd3, 4'hA, 4'd3, 4'd7, 4'd0};
      dc39  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
      start(16'h3370);
      for (int i = 0; i < 5; i++) begin
         press(seq39[i]);
         check("bcd_count", bus_if.digit_count, dc39[i]);
      end
      tick();
      tick();
      check("bcd_ok", bus_if.pin_ok, 1);
      pulse_card_out();
      check("bcd_card_out", bus_if.pin_ok, 0);

      // Timeout: one digit then 8 quiet cycles
      start(16'h1234);
      press(4'd1);
      early_eject = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         early_eject = early_eject | bus_if.eject_card;
      end
      check("to_no_early", early_eject, 0);
      tick();
      check("to_eject", bus_if.eject_card, 1);
      tick();
      check("to_eject_end", bus_if.eject_card, 0);
      check("to_idle_tries", bus_if.tries_left, 0);
      check("to_idle_count", bus_if.digit_count, 0);

      // card_out mid-entry
      start(16'h1234);
      press(4'd1); press(4'd2);
      check("co_count2", bus_if.digit_count, 2);
      pulse_card_out();
      check("co_count0", bus_if.digit_count, 0);
      check("co_tries0", bus_if.tries_left, 0);

      // Reset during CHECK with a correct PIN: no grant must survive
      start(16'h4321);
      press(4'd4); press(4'd3); press(4'd2); press(4'd1);
      tick();
      reset_n = 1'b0;
      #1;
      check("rstchk_count", bus_if.digit_count, 0);
      check("rstchk_tries", bus_if.tries_left, 0);
      check("rstchk_ok", bus_if.pin_ok, 0);
      #2 reset_n = 1'b1;
      tick();
      tick();
      check("rstchk_after_ok", bus_if.pin_ok, 0);
      check("rstchk_after_tries", bus_if.tries_left, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
